// File: rtl/data_mem_pkg.sv
// Shared types and default sizes for the data memory arbiter.
package data_mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    localparam int unsigned BURST_MAX_DEF = 4;
    localparam int unsigned ADDR_W_DEF    = 32;
    localparam int unsigned DATA_W_DEF    = 32;

    // Burst counter wide enough for BURST_MAX up to 16
    localparam int unsigned CNT_W = 4;

    // Port opposite to p; anything other than A maps to A so A wins ties
    function automatic owner_t other_port(input owner_t p);
        return (p == OWN_A) ? OWN_B : OWN_A;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select: bounded-burst round robin between ports A and B.
module arb_pick
    import data_mem_pkg::*;
#(
    parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
    input  owner_t             owner,
    input  logic [CNT_W-1:0]   burst_cnt,
    input  owner_t             last_winner,
    input  logic               req_a,
    input  logic               req_b,
    output owner_t             win
);

    logic req_own;
    logic req_oth;
    logic expired;

    // Keep the owner while its burst lasts, otherwise hand over to a requesting peer
    always_comb begin
        win     = OWN_NONE;
        req_own = (owner == OWN_A) ? req_a : req_b;
        req_oth = (owner == OWN_A) ? req_b : req_a;
        expired = (burst_cnt >= CNT_W'(BURST_MAX - 1));

        if (owner == OWN_NONE) begin
            if (req_a && req_b) begin
                win = other_port(last_winner);
            end else if (req_a) begin
                win = OWN_A;
            end else if (req_b) begin
                win = OWN_B;
            end
        end else if (req_own && !expired) begin
            win = owner;
        end else if (req_oth) begin
            win = other_port(owner);
        end else if (req_own) begin
            win = owner;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-ported data memory between port A (load/store) and port B (loader/debug).
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int unsigned BURST_MAX = BURST_MAX_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ReqA,
    input  logic              WeA,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [DATA_W-1:0] WdataA,
    input  logic              ReqB,
    input  logic              WeB,
    input  logic [ADDR_W-1:0] AddrB,
    input  logic [DATA_W-1:0] WdataB,
    output logic              GntA,
    output logic              GntB,
    output logic              RvalidA,
    output logic              RvalidB,
    output logic [DATA_W-1:0] RdataA,
    output logic [DATA_W-1:0] RdataB,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData
);

    owner_t           owner;
    owner_t           last_winner;
    owner_t           win;
    logic [CNT_W-1:0] burst_cnt;

    arb_pick #(
        .BURST_MAX (BURST_MAX)
    ) u_pick (
        .owner       (owner),
        .burst_cnt   (burst_cnt),
        .last_winner (last_winner),
        .req_a       (ReqA),
        .req_b       (ReqB),
        .win         (win)
    );

    // Grants and memory mux from the winner; everything is held low during reset
    always_comb begin
        GntA      = 1'b0;
        GntB      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = '0;
        WriteData = '0;
        if (!reset) begin
            case (win)
                OWN_A: begin
                    GntA      = 1'b1;
                    MemRead   = ~WeA;
                    MemWrite  = WeA;
                    Address   = AddrA;
                    WriteData = WdataA;
                end
                OWN_B: begin
                    GntB      = 1'b1;
                    MemRead   = ~WeB;
                    MemWrite  = WeB;
                    Address   = AddrB;
                    WriteData = WdataB;
                end
                default: ;
            endcase
        end
    end

    // Ownership, burst length and tie-break history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner       <= OWN_NONE;
            burst_cnt   <= '0;
            last_winner <= OWN_B;
        end else begin
            owner <= win;
            if ((win == owner) && (burst_cnt < CNT_W'(BURST_MAX - 1))) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end else begin
                burst_cnt <= '0;
            end
            if (win != OWN_NONE) begin
                last_winner <= win;
            end
        end
    end

    // Read responses one cycle after the grant; data holds between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RvalidA <= 1'b0;
            RvalidB <= 1'b0;
            RdataA  <= '0;
            RdataB  <= '0;
        end else begin
            RvalidA <= GntA & ~WeA;
            RvalidB <= GntB & ~WeB;
            if (GntA && !WeA) begin
                RdataA <= ReadData;
            end
            if (GntB && !WeB) begin
                RdataB <= ReadData;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a small behavioural memory.
module tb_data_mem_arbiter;
    import data_mem_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          ReqA, WeA, ReqB, WeB;
    logic [AW-1:0] AddrA, AddrB;
    logic [DW-1:0] WdataA, WdataB;
    logic          GntA, GntB, RvalidA, RvalidB, MemRead, MemWrite;
    logic [DW-1:0] RdataA, RdataB, WriteData, ReadData;
    logic [AW-1:0] Address;

    int checks = 0;
    int fails  = 0;

    logic [DW-1:0] mem [256] = '{1: 32'hAAAA0001, 2: 32'hBBBB0002, 5: 32'hDEADBEEF, default: 32'h0};

    assign ReadData = mem[Address[7:0]];
    always @(posedge clk) if (MemWrite) mem[Address[7:0]] <= WriteData;

    always #5 clk = ~clk;

    data_mem_arbiter #(.BURST_MAX(4), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .ReqA(ReqA), .WeA(WeA), .AddrA(AddrA), .WdataA(WdataA),
        .ReqB(ReqB), .WeB(WeB), .AddrB(AddrB), .WdataB(WdataB),
        .GntA(GntA), .GntB(GntB), .RvalidA(RvalidA), .RvalidB(RvalidB),
        .RdataA(RdataA), .RdataB(RdataB), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
    );

    task automatic idle_inputs();
        ReqA = 1'b0; WeA = 1'b0; AddrA = '0; WdataA = '0;
        ReqB = 1'b0; WeB = 1'b0; AddrB = '0; WdataB = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        #1 reset = 1'b1;
        ReqA = 1'b1; ReqB = 1'b1;
        #2;
        checks++;
        if ({GntA, GntB, MemRead, MemWrite} !== 4'b0000) begin
            fails++; $display("FAIL reset_gnt_mem: got %b expected 0000", {GntA, GntB, MemRead, MemWrite});
        end
        checks++;
        if ({RvalidA, RvalidB} !== 2'b00 || RdataA !== 32'h0 || RdataB !== 32'h0) begin
            fails++; $display("FAIL reset_resp: got rv=%b ra=%h rb=%h expected 0", {RvalidA, RvalidB}, RdataA, RdataB);
        end
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        ReqA = 1'b1; WeA = 1'b0; AddrA = 32'd5;
        @(negedge clk);
        checks++;
        if (GntA !== 1'b1 || GntB !== 1'b0 || MemRead !== 1'b1 || MemWrite !== 1'b0 || Address !== 32'd5) begin
            fails++; $display("FAIL single_read_gnt: got gA=%b gB=%b rd=%b wr=%b addr=%h expected 1 0 1 0 5", GntA, GntB, MemRead, MemWrite, Address);
        end
        @(posedge clk); #1;
        idle_inputs();
        checks++;
        if (RvalidA !== 1'b1 || RdataA !== 32'hDEADBEEF) begin
            fails++; $display("FAIL single_read_resp: got rv=%b data=%h expected 1 deadbeef", RvalidA, RdataA);
        end
        checks++;
        if (GntB !== 1'b0 || RvalidB !== 1'b0 || RdataB !== 32'h0) begin
            fails++; $display("FAIL single_read_b_quiet: got g=%b rv=%b data=%h expected 0", GntB, RvalidB, RdataB);
        end
        @(posedge clk); #1;
        checks++;
        if (RvalidA !== 1'b0 || RdataA !== 32'hDEADBEEF) begin
            fails++; $display("FAIL single_read_hold: got rv=%b data=%h expected 0 deadbeef", RvalidA, RdataA);
        end
    endtask

    task automatic test_round_robin();
        logic exp_a;
        do_reset();
        ReqA = 1'b1; AddrA = 32'd1;
        ReqB = 1'b1; AddrB = 32'd2;
        for (int i = 0; i < 12; i++) begin
            exp_a = (i < 4) || (i >= 8);
            @(negedge clk);
            checks++;
            if (GntA !== exp_a || GntB !== ~exp_a) begin
                fails++; $display("FAIL rr_gnt[%0d]: got A=%b B=%b expected A=%b B=%b", i, GntA, GntB, exp_a, ~exp_a);
            end
            @(posedge clk); #1;
            checks++;
            if (RvalidA !== exp_a || RvalidB !== ~exp_a ||
                (exp_a && RdataA !== 32'hAAAA0001) || (!exp_a && RdataB !== 32'hBBBB0002)) begin
                fails++; $display("FAIL rr_resp[%0d]: got rvA=%b rvB=%b dA=%h dB=%h", i, RvalidA, RvalidB, RdataA, RdataB);
            end
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_write_then_read();
        ReqA = 1'b1; WeA = 1'b1; AddrA = 32'd16; WdataA = 32'h12345678;
        @(negedge clk);
        checks++;
        if (GntA !== 1'b1 || MemWrite !== 1'b1 || MemRead !== 1'b0 || Address !== 32'd16 || WriteData !== 32'h12345678) begin
            fails++; $display("FAIL wr_issue: got g=%b wr=%b rd=%b addr=%h wd=%h", GntA, MemWrite, MemRead, Address, WriteData);
        end
        @(posedge clk); #1;
        idle_inputs();
        ReqB = 1'b1; WeB = 1'b0; AddrB = 32'd16;
        checks++;
        if (RvalidA !== 1'b0 || mem[16] !== 32'h12345678) begin
            fails++; $display("FAIL wr_done: got rvA=%b mem16=%h expected 0 12345678", RvalidA, mem[16]);
        end
        @(negedge clk);
        checks++;
        if (GntB !== 1'b1 || GntA !== 1'b0 || MemRead !== 1'b1) begin
            fails++; $display("FAIL raw_gnt: got gB=%b gA=%b rd=%b expected 1 0 1", GntB, GntA, MemRead);
        end
        @(posedge clk); #1;
        idle_inputs();
        checks++;
        if (RvalidB !== 1'b1 || RdataB !== 32'h12345678) begin
            fails++; $display("FAIL raw_data: got rv=%b data=%h expected 1 12345678", RvalidB, RdataB);
        end
    endtask

    task automatic test_solo_burst();
        logic [3:0] exp_cnt;
        do_reset();
        ReqA = 1'b1; AddrA = 32'd5;
        for (int i = 0; i < 10; i++) begin
            exp_cnt = (i == 0) ? 4'd0 : 4'((i - 1) % 4);
            @(negedge clk);
            checks++;
            if (GntA !== 1'b1 || GntB !== 1'b0 || dut.burst_cnt !== exp_cnt) begin
                fails++; $display("FAIL solo[%0d]: got gA=%b gB=%b cnt=%0d expected 1 0 %0d", i, GntA, GntB, dut.burst_cnt, exp_cnt);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_drop();
        do_reset();
        ReqA = 1'b1; AddrA = 32'd1;
        ReqB = 1'b1; AddrB = 32'd2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (GntA !== 1'b1 || GntB !== 1'b0) begin
                fails++; $display("FAIL drop_pre[%0d]: got A=%b B=%b expected 1 0", i, GntA, GntB);
            end
            @(posedge clk); #1;
        end
        ReqA = 1'b0;
        @(negedge clk);
        checks++;
        if (GntB !== 1'b1 || GntA !== 1'b0) begin
            fails++; $display("FAIL drop_switch: got A=%b B=%b expected 0 1", GntA, GntB);
        end
        @(posedge clk); #1;
        checks++;
        if (dut.burst_cnt !== 4'd0 || RvalidB !== 1'b1 || RdataB !== 32'hBBBB0002) begin
            fails++; $display("FAIL drop_cnt: got cnt=%0d rvB=%b dB=%h expected 0 1 bbbb0002", dut.burst_cnt, RvalidB, RdataB);
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        ReqA = 1'b1; AddrA = 32'd5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (GntA !== 1'b1 || dut.burst_cnt !== 4'd2 || RvalidA !== 1'b1) begin
            fails++; $display("FAIL mid_pre: got gA=%b cnt=%0d rvA=%b expected 1 2 1", GntA, dut.burst_cnt, RvalidA);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (GntA !== 1'b0 || MemRead !== 1'b0 || RvalidA !== 1'b0 || dut.burst_cnt !== 4'd0) begin
            fails++; $display("FAIL mid_async: got gA=%b rd=%b rvA=%b cnt=%0d expected 0 0 0 0", GntA, MemRead, RvalidA, dut.burst_cnt);
        end
        ReqB = 1'b1; AddrB = 32'd2;
        @(posedge clk); #1;
        checks++;
        if (GntA !== 1'b0 || GntB !== 1'b0 || RvalidA !== 1'b0) begin
            fails++; $display("FAIL mid_held: got gA=%b gB=%b rvA=%b expected 0 0 0", GntA, GntB, RvalidA);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (GntA !== 1'b1 || GntB !== 1'b0) begin
            fails++; $display("FAIL mid_release: got A=%b B=%b expected 1 0", GntA, GntB);
        end
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_then_read();
        test_solo_burst();
        test_drop();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
